// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with start/busy/done.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borr_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-2:0] rd_q, rd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bq_q, bq_d;
  logic             borr_q, borr_d;
  logic             done_q, done_d;

  logic             ai, bi, d1, b1, b2, dbit;
  logic [WIDTH-1:0] rd_full;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Two chained half-subtractors form the per-bit full-subtract cell.
  assign ai      = ra_q[0];
  assign bi      = rb_q[0];
  assign d1      = ai ^ bi;
  assign b1      = ~ai & bi;
  assign dbit    = d1 ^ bq_q;
  assign b2      = ~d1 & bq_q;
  assign rd_full = {dbit, rd_q};
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bq_d    = bq_q;
    borr_d  = borr_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          bq_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bq_d  = b1 | b2;
        rd_d  = rd_full[WIDTH-1:1];
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = rd_full;
          borr_d  = b1 | b2;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit ai/bi are the operand MSBs.
          ovf_d   = (ai != bi) && (dbit != ai);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bq_q    <= 1'b0;
      borr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bq_q    <= bq_d;
      borr_q  <= borr_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign diff     = diff_q;
  assign borr_out = borr_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table,
// random operations against an arithmetic model, handshake corner cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borr_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf      (ovf),
`endif
    .borr_out (borr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  logic [W-1:0] held_d;
  logic         held_b;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One full operation, started on the negedge after the call.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    int n;
    int sd;
    logic [W-1:0] ed;
    logic eb;
    ed = ta - tb_;
    eb = (ta < tb_);
    sd = int'($signed(ta)) - int'($signed(tb_));
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
      if (n == W / 2) begin
        chk("busy_mid", busy, 1);
        chk("diff_held_mid", diff, held_d);
        chk("borr_held_mid", borr_out, held_b);
      end
    end
    chk("latency", n, W);
    chk("busy_at_done", busy, 0);
    chk("diff", diff, ed);
    chk("borr_out", borr_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, (sd > 127 || sd < -128) ? 1 : 0);
`else
    if (sd == 12345) $display("unreachable");
`endif
    held_d = ed;
    held_b = eb;
  endtask

  initial begin
    vec_t vt[6];
    int   pulses;
    logic [W-1:0] gd;
    logic         gb;

    vt[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vt[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vt[5] = '{8'h7F, 8'h01, 8'h7E, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    held_d = '0; held_b = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borr", borr_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].va, vt[i].vb);
      chk("tbl_diff", diff, vt[i].ed);
      chk("tbl_borr", borr_out, vt[i].eb);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("diff_kept_idle", diff, held_d);

    // start while busy must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; gd = '0; gb = 1'b0;
    for (int k = 0; k < 3 * W; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        gd = diff;
        gb = borr_out;
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_diff", gd, 8'h0F);
    chk("ign_borr", gb, 0);
    held_d = 8'h0F; held_b = 1'b0;

    // back-to-back: second start lands in the done cycle
    do_op(8'h20, 8'h10);
    do_op(8'h10, 8'h20);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_borr", borr_out, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    held_d = '0; held_b = 1'b0;
    do_op(8'h09, 8'h04);

    for (int r = 0; r < 30; r++) begin
      do_op(W'($urandom), W'($urandom));
    end
    do_op(8'h00, 8'hFF);
    do_op(8'hFF, 8'hFF);
    @(posedge clk); #1;
    chk("done_cleared", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
